// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with START/BUSY/DONE handshake.
//
// Single-cycle ops update OUT/flags at the edge that samples IN_START and
// pulse DONE for one cycle. MUL runs an iterative shift-add multiplier for
// DWIDTH cycles, then writes the double-width product to {OUT_HI, OUT}.
// The carry/borrow/zero flags are held internally so ADC/SBB can chain.
//
// Ports:
//   CLK       clock, all state on rising edge
//   RST       synchronous active-high reset
//   IN_START  request; captures IN_INSTR/IN_A/IN_B (ignored while BUSY)
//   IN_INSTR  4-bit opcode
//   IN_A/IN_B operands (DWIDTH bits)
//   OUT       registered result (MUL: low half)
//   OUT_HI    MUL high half, 0 after other result-producing ops
//   FLAG_C/FLAG_B/FLAG_Z  carry / borrow / zero flags
//   BUSY      multiplication in progress
//   DONE      one-cycle pulse, result and flags valid
module alu_mc #(
  parameter int DWIDTH = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_START,
  input  logic [3:0]        IN_INSTR,
  input  logic [DWIDTH-1:0] IN_A,
  input  logic [DWIDTH-1:0] IN_B,
  output logic [DWIDTH-1:0] OUT,
  output logic [DWIDTH-1:0] OUT_HI,
  output logic              FLAG_C,
  output logic              FLAG_B,
  output logic              FLAG_Z,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CW = $clog2(DWIDTH + 1);

  localparam logic [3:0] OP_NOP = 4'h0, OP_AND = 4'h1, OP_OR  = 4'h2,
                         OP_XOR = 4'h3, OP_SUB = 4'h4, OP_ADD = 4'h5,
                         OP_ADC = 4'h6, OP_SBB = 4'h7, OP_DEC = 4'h8,
                         OP_INC = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
                         OP_MUL = 4'hC;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t                state_reg, state_next;
  logic [DWIDTH-1:0]     out_reg, out_next;
  logic [DWIDTH-1:0]     out_hi_reg, out_hi_next;
  logic                  c_reg, c_next, b_reg, b_next, z_reg, z_next;
  logic                  busy_reg, busy_next, done_reg, done_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DWIDTH-1:0]     mcand_reg, mcand_next;
  // Product register: high half accumulates, low half holds the remaining
  // multiplier bits and fills with product bits as it shifts right.
  logic [2*DWIDTH-1:0]   prod_reg, prod_next;

  // Single-cycle ALU result
  logic [DWIDTH-1:0]     alu_res;
  logic                  alu_c, alu_b, alu_wr;
  logic [DWIDTH:0]       wide;

  // One shift-add step
  logic [DWIDTH:0]       step_sum;
  logic [2*DWIDTH-1:0]   step_prod;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_b   = 1'b0;
    alu_wr  = 1'b1;
    wide    = '0;
    case (IN_INSTR)
      OP_AND: alu_res = IN_A & IN_B;
      OP_OR:  alu_res = IN_A | IN_B;
      OP_XOR: alu_res = IN_A ^ IN_B;
      OP_SUB: begin
        wide    = {1'b0, IN_A} - {1'b0, IN_B};
        alu_res = wide[DWIDTH-1:0];
        alu_b   = wide[DWIDTH];
      end
      OP_ADD: begin
        wide    = {1'b0, IN_A} + {1'b0, IN_B};
        alu_res = wide[DWIDTH-1:0];
        alu_c   = wide[DWIDTH];
      end
      OP_ADC: begin
        wide    = {1'b0, IN_A} + {1'b0, IN_B} + {{DWIDTH{1'b0}}, c_reg};
        alu_res = wide[DWIDTH-1:0];
        alu_c   = wide[DWIDTH];
      end
      OP_SBB: begin
        // N+1-bit difference: its top bit is set exactly when A < B+borrow
        wide    = {1'b0, IN_A} - {1'b0, IN_B} - {{DWIDTH{1'b0}}, b_reg};
        alu_res = wide[DWIDTH-1:0];
        alu_b   = wide[DWIDTH];
      end
      OP_DEC: begin
        alu_res = IN_A - 1'b1;
        alu_b   = (IN_A == '0);
      end
      OP_INC: begin
        alu_res = IN_A + 1'b1;
        alu_c   = (IN_A == '1);
      end
      OP_SHL: begin
        alu_res = {IN_A[DWIDTH-2:0], 1'b0};
        alu_c   = IN_A[DWIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, IN_A[DWIDTH-1:1]};
        alu_c   = IN_A[0];
      end
      default: alu_wr = 1'b0;   // NOP, undefined, and MUL (handled below)
    endcase
  end

  always_comb begin
    step_sum  = {1'b0, prod_reg[2*DWIDTH-1:DWIDTH]}
              + ({(DWIDTH+1){prod_reg[0]}} & {1'b0, mcand_reg});
    step_prod = {step_sum, prod_reg[DWIDTH-1:1]};
  end

  always_comb begin
    state_next  = state_reg;
    out_next    = out_reg;
    out_hi_next = out_hi_reg;
    c_next      = c_reg;
    b_next      = b_reg;
    z_next      = z_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    cnt_next    = cnt_reg;
    mcand_next  = mcand_reg;
    prod_next   = prod_reg;
    case (state_reg)
      ST_IDLE: begin
        if (IN_START) begin
          if (MUL_EN && IN_INSTR == OP_MUL) begin
            mcand_next = IN_A;
            prod_next  = {{DWIDTH{1'b0}}, IN_B};
            cnt_next   = CW'(DWIDTH);
            busy_next  = 1'b1;
            state_next = ST_MUL;
          end else begin
            done_next = 1'b1;
            if (alu_wr) begin
              out_next    = alu_res;
              out_hi_next = '0;
              c_next      = alu_c;
              b_next      = alu_b;
              z_next      = (alu_res == '0);
            end
          end
        end
      end
      ST_MUL: begin
        prod_next = step_prod;
        cnt_next  = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          out_next    = step_prod[DWIDTH-1:0];
          out_hi_next = step_prod[2*DWIDTH-1:DWIDTH];
          c_next      = (step_prod[2*DWIDTH-1:DWIDTH] != '0);
          b_next      = 1'b0;
          z_next      = (step_prod == '0);
          busy_next   = 1'b0;
          done_next   = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      out_reg    <= '0;
      out_hi_reg <= '0;
      c_reg      <= 1'b0;
      b_reg      <= 1'b0;
      z_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      out_reg    <= out_next;
      out_hi_reg <= out_hi_next;
      c_reg      <= c_next;
      b_reg      <= b_next;
      z_reg      <= z_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      cnt_reg    <= cnt_next;
      mcand_reg  <= mcand_next;
      prod_reg   <= prod_next;
    end
  end

  assign OUT    = out_reg;
  assign OUT_HI = out_hi_reg;
  assign FLAG_C = c_reg;
  assign FLAG_B = b_reg;
  assign FLAG_Z = z_reg;
  assign BUSY   = busy_reg;
  assign DONE   = done_reg;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed, table-driven bench for alu_mc (DWIDTH=8, MUL_EN=1),
// plus hand-written sequences for the handshake corner cases.
module tb_alu_mc;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_START = 1'b0;
  logic [3:0] IN_INSTR = 4'h0;
  logic [7:0] IN_A = 8'h00;
  logic [7:0] IN_B = 8'h00;
  logic [7:0] OUT, OUT_HI;
  logic       FLAG_C, FLAG_B, FLAG_Z, BUSY, DONE;

  alu_mc #(.DWIDTH(8), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .IN_START(IN_START), .IN_INSTR(IN_INSTR),
    .IN_A(IN_A), .IN_B(IN_B), .OUT(OUT), .OUT_HI(OUT_HI),
    .FLAG_C(FLAG_C), .FLAG_B(FLAG_B), .FLAG_Z(FLAG_Z),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e_out;
    logic [7:0] e_hi;
    logic       e_c;
    logic       e_b;
    logic       e_z;
    int         e_lat;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int lat;
    logic busy_cap;
    @(negedge CLK);
    IN_INSTR = v.op; IN_A = v.a; IN_B = v.b; IN_START = 1'b1;
    @(posedge CLK); #1;
    IN_START = 1'b0;
    busy_cap = BUSY;
    lat = 0;
    while (!DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    $display("op=%0h a=%02h b=%02h -> out=%02h hi=%02h c=%0b b=%0b z=%0b lat=%0d",
             v.op, v.a, v.b, OUT, OUT_HI, FLAG_C, FLAG_B, FLAG_Z, lat);
    chk("latency", lat, v.e_lat);
    chk("busy_at_capture", busy_cap, (v.e_lat > 0));
    chk("out", OUT, v.e_out);
    chk("out_hi", OUT_HI, v.e_hi);
    chk("flag_c", FLAG_C, v.e_c);
    chk("flag_b", FLAG_B, v.e_b);
    chk("flag_z", FLAG_Z, v.e_z);
    chk("busy_at_done", BUSY, 0);
    @(posedge CLK); #1;
    chk("done_one_cycle", DONE, 0);
  endtask

  initial begin
    int lat, busy_cnt, done_cnt;

    //            op    a      b      out    hi     c  b  z  lat
    vq.push_back(vec_t'{4'h5, 8'h04, 8'h02, 8'h06, 8'h00, 0, 0, 0, 0});  // ADD
    vq.push_back(vec_t'{4'h5, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 1, 0});  // ADD wrap
    vq.push_back(vec_t'{4'h6, 8'h0A, 8'h0B, 8'h16, 8'h00, 0, 0, 0, 0});  // ADC C=1
    vq.push_back(vec_t'{4'h6, 8'h04, 8'h02, 8'h06, 8'h00, 0, 0, 0, 0});  // ADC C=0
    vq.push_back(vec_t'{4'h4, 8'h03, 8'h1F, 8'hE4, 8'h00, 0, 1, 0, 0});  // SUB
    vq.push_back(vec_t'{4'h7, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 0});  // SBB B=1
    vq.push_back(vec_t'{4'h7, 8'h04, 8'h02, 8'h01, 8'h00, 0, 0, 0, 0});  // SBB B=1
    vq.push_back(vec_t'{4'h8, 8'h70, 8'h00, 8'h6F, 8'h00, 0, 0, 0, 0});  // DEC
    vq.push_back(vec_t'{4'h8, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 0});  // DEC 0
    vq.push_back(vec_t'{4'h7, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1, 1, 0});  // SBB 0-FF-1
    vq.push_back(vec_t'{4'hC, 8'h0F, 8'h11, 8'hFF, 8'h00, 0, 0, 0, 8});  // MUL
    vq.push_back(vec_t'{4'hC, 8'h00, 8'h5A, 8'h00, 8'h00, 0, 0, 1, 8});  // MUL zero
    vq.push_back(vec_t'{4'hC, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1, 0, 0, 8});  // MUL max
    vq.push_back(vec_t'{4'h0, 8'h12, 8'h34, 8'h01, 8'hFE, 1, 0, 0, 0});  // NOP keeps all
    vq.push_back(vec_t'{4'h9, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0});  // INC FF
    vq.push_back(vec_t'{4'hA, 8'h81, 8'h00, 8'h02, 8'h00, 1, 0, 0, 0});  // SHL
    vq.push_back(vec_t'{4'hB, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0});  // SHR
    vq.push_back(vec_t'{4'hF, 8'h77, 8'h66, 8'h00, 8'h00, 1, 0, 1, 0});  // undefined
    vq.push_back(vec_t'{4'h1, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0});  // AND
    vq.push_back(vec_t'{4'h2, 8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0, 0});  // OR
    vq.push_back(vec_t'{4'h3, 8'hAA, 8'hFF, 8'h55, 8'h00, 0, 0, 0, 0});  // XOR
    vq.push_back(vec_t'{4'hD, 8'h00, 8'h00, 8'h55, 8'h00, 0, 0, 0, 0});  // undefined

    // Reset, with IN_START asserted to show reset wins
    IN_START = 1'b1; IN_INSTR = 4'h5; IN_A = 8'h04; IN_B = 8'h02;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out", OUT, 0);
    chk("rst_hi", OUT_HI, 0);
    chk("rst_flags", {FLAG_C, FLAG_B, FLAG_Z}, 0);
    chk("rst_busy_done", {BUSY, DONE}, 0);
    @(negedge CLK);
    RST = 1'b0; IN_START = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply_vec(vq[i]);

    // MUL with START pulses and operand changes during BUSY
    @(negedge CLK);
    IN_INSTR = 4'hC; IN_A = 8'h0F; IN_B = 8'h11; IN_START = 1'b1;
    @(posedge CLK); #1;
    IN_START = 1'b0;
    busy_cnt = BUSY ? 1 : 0;
    lat = 0;
    while (!DONE && lat < 40) begin
      @(negedge CLK);
      IN_INSTR = 4'h5; IN_A = 8'($urandom); IN_B = 8'($urandom); IN_START = lat[0];
      @(posedge CLK); #1;
      lat++;
      if (BUSY) busy_cnt++;
    end
    IN_START = 1'b0;
    $display("busy-ignore MUL 0F*11 -> out=%02h hi=%02h lat=%0d busy=%0d", OUT, OUT_HI, lat, busy_cnt);
    chk("ign_latency", lat, 8);
    chk("ign_busy_cycles", busy_cnt, 8);
    chk("ign_out", OUT, 8'hFF);
    chk("ign_hi", OUT_HI, 8'h00);
    @(posedge CLK); #1;
    chk("ign_no_extra_done", DONE, 0);
    chk("ign_out_stable", OUT, 8'hFF);

    // START in the DONE cycle after MUL is accepted
    @(negedge CLK);
    IN_INSTR = 4'hC; IN_A = 8'h02; IN_B = 8'h03; IN_START = 1'b1;
    @(posedge CLK); #1;
    IN_START = 1'b0;
    lat = 0;
    while (!DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("b2b_mul_out", OUT, 8'h06);
    IN_INSTR = 4'h5; IN_A = 8'h01; IN_B = 8'h01; IN_START = 1'b1;
    @(posedge CLK); #1;
    IN_START = 1'b0;
    $display("back-to-back ADD 01+01 after MUL -> out=%02h done=%0b", OUT, DONE);
    chk("b2b_add_out", OUT, 8'h02);
    chk("b2b_add_done", DONE, 1);
    chk("b2b_add_busy", BUSY, 0);

    // START held high for 4 ADDs
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      IN_INSTR = 4'h5; IN_A = 8'h10; IN_B = 8'(i); IN_START = 1'b1;
      @(posedge CLK); #1;
      $display("held ADD 10+%02h -> out=%02h done=%0b", i, OUT, DONE);
      chk("held_done", DONE, 1);
      chk("held_out", OUT, 8'h10 + 8'(i));
    end
    IN_START = 1'b0;
    @(posedge CLK); #1;
    chk("held_done_drop", DONE, 0);

    // Reset three cycles into a MUL
    @(negedge CLK);
    IN_INSTR = 4'hC; IN_A = 8'hFF; IN_B = 8'hFF; IN_START = 1'b1;
    @(posedge CLK); #1;
    IN_START = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_out", OUT, 0);
    chk("abort_hi", OUT_HI, 0);
    chk("abort_flags", {FLAG_C, FLAG_B, FLAG_Z}, 0);
    chk("abort_busy_done", {BUSY, DONE}, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) done_cnt++;
    end
    $display("reset mid-MUL -> out=%02h hi=%02h stray=%0d", OUT, OUT_HI, done_cnt);
    chk("abort_no_done", done_cnt, 0);
    apply_vec(vec_t'{4'h9, 8'h20, 8'h00, 8'h21, 8'h00, 0, 0, 0, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
